turn_controller: RTL and testbench

- Control-unit FSM that drives the game datapath for one turn at a time.
- Handles player input: card cursor, confirm, and a timed card reveal.
- Issues strobes to the datapath: card-check A, move B, and next-turn pulse statecombo_next_turn.
- Consumes the datapath responses go and W, and decides whether the same player continues, the turn passes, or the game ends.

---
 rtl/turn_controller.sv | 153 +++++++++++++++
 tb/tb_turn_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// ============================================================================
// turn_controller : one-turn control FSM for the card-matching game datapath
// Revision        : 1.0
// ============================================================================
`default_nettype none

module turn_controller #(
  parameter int REVEAL_CYCLES = 50000000,
  parameter int CNT_W         = 26,
  parameter int NUM_CARDS     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_btn,
  input  logic       ok_btn,
  input  logic       go,
  input  logic       W,
  output logic [3:0] position_data,
  output logic       A,
  output logic       B,
  output logic       statecombo_next_turn,
  output logic       reveal,
  output logic       winner,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SELECT     = 4'd1,
    S_REVEAL     = 4'd2,
    S_CHECK_REQ  = 4'd3,
    S_CHECK_WAIT = 4'd4,
    S_MOVE       = 4'd5,
    S_WIN_CHECK  = 4'd6,
    S_NEXT       = 4'd7,
    S_GAMEOVER   = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] C_REVEAL_LAST = CNT_W'(REVEAL_CYCLES - 1);
  localparam logic [3:0]       C_LAST_CARD   = 4'(NUM_CARDS - 1);

  state_t           state_q;
  logic [3:0]       pos_q;
  logic [CNT_W-1:0] timer_q;
  logic             a_q, b_q, nt_q, reveal_q, winner_q;
  logic             start_prev_q, sel_prev_q, ok_prev_q;

  logic       start_ev, sel_ev, ok_ev;
  logic [3:0] pos_inc;

  assign start_ev = start   & ~start_prev_q;
  assign sel_ev   = sel_btn & ~sel_prev_q;
  assign ok_ev    = ok_btn  & ~ok_prev_q;
  assign pos_inc  = (pos_q == C_LAST_CARD) ? 4'd0 : pos_q + 4'd1;

  // Previous-value registers reset high so a button held across reset is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pos_q        <= 4'd0;
      timer_q      <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      nt_q         <= 1'b0;
      reveal_q     <= 1'b0;
      winner_q     <= 1'b0;
      start_prev_q <= 1'b1;
      sel_prev_q   <= 1'b1;
      ok_prev_q    <= 1'b1;
    end else begin
      start_prev_q <= start;
      sel_prev_q   <= sel_btn;
      ok_prev_q    <= ok_btn;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      nt_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            state_q <= S_SELECT;
            pos_q   <= 4'd0;
          end
        end
        S_SELECT: begin
          if (ok_ev) begin
            state_q  <= S_REVEAL;
            timer_q  <= '0;
            reveal_q <= 1'b1;
          end else if (sel_ev) begin
            pos_q <= pos_inc;
          end
        end
        S_REVEAL: begin
          if (timer_q == C_REVEAL_LAST) begin
            state_q  <= S_CHECK_REQ;
            reveal_q <= 1'b0;
            a_q      <= 1'b1;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        S_CHECK_REQ: state_q <= S_CHECK_WAIT;
        S_CHECK_WAIT: begin
          if (go) begin
            state_q <= S_MOVE;
            b_q     <= 1'b1;
          end else begin
            state_q <= S_NEXT;
            nt_q    <= 1'b1;
          end
        end
        S_MOVE: state_q <= S_WIN_CHECK;
        S_WIN_CHECK: begin
          if (W) begin
            state_q  <= S_GAMEOVER;
            winner_q <= 1'b1;
          end else begin
            state_q <= S_SELECT;
          end
        end
        S_NEXT: begin
          state_q <= S_SELECT;
          pos_q   <= 4'd0;
        end
        S_GAMEOVER: begin
          if (start_ev) begin
            state_q  <= S_IDLE;
            winner_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          pos_q    <= 4'd0;
          timer_q  <= '0;
          reveal_q <= 1'b0;
          winner_q <= 1'b0;
        end
      endcase
    end
  end

  assign position_data        = pos_q;
  assign A                    = a_q;
  assign B                    = b_q;
  assign statecombo_next_turn = nt_q;
  assign reveal               = reveal_q;
  assign winner               = winner_q;
  assign state                = state_q;

endmodule

`default_nettype wire

// File: tb/tb_turn_controller.sv
// ============================================================================
// tb_turn_controller : table-driven check of turn_controller (REVEAL_CYCLES=4)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_turn_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, sel_btn = 1'b0, ok_btn = 1'b1, go = 1'b0, W = 1'b0;
  logic [3:0] position_data, state;
  logic       A, B, statecombo_next_turn, reveal, winner;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       st, se, ok, g, w;
    logic [3:0] state, pos;
    logic       a, b, nt, rv, wn;
  } vec_t;

  vec_t vq[$];

  turn_controller #(
    .REVEAL_CYCLES(4),
    .CNT_W        (3),
    .NUM_CARDS    (12)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .sel_btn             (sel_btn),
    .ok_btn              (ok_btn),
    .go                  (go),
    .W                   (W),
    .position_data       (position_data),
    .A                   (A),
    .B                   (B),
    .statecombo_next_turn(statecombo_next_turn),
    .reveal              (reveal),
    .winner              (winner),
    .state               (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, se, ok, g, w,
                              input logic [3:0] s, p,
                              input logic a, b, nt, rv, wn);
    vec_t v;
    v.st = st; v.se = se; v.ok = ok; v.g = g; v.w = w;
    v.state = s; v.pos = p;
    v.a = a; v.b = b; v.nt = nt; v.rv = rv; v.wn = wn;
    return v;
  endfunction

  function automatic void add(input logic st, se, ok, g, w,
                              input logic [3:0] s, p,
                              input logic a, b, nt, rv, wn);
    vq.push_back(mk(st, se, ok, g, w, s, p, a, b, nt, rv, wn));
  endfunction

  task automatic check(input string name, input vec_t v);
    logic [12:0] act, exp;
    act = {state, position_data, A, B, statecombo_next_turn, reveal, winner};
    exp = {v.state, v.pos, v.a, v.b, v.nt, v.rv, v.wn};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got state=%0d pos=%0d A=%b B=%b nt=%b rev=%b win=%b, want state=%0d pos=%0d A=%b B=%b nt=%b rev=%b win=%b",
               name, state, position_data, A, B, statecombo_next_turn, reveal, winner,
               v.state, v.pos, v.a, v.b, v.nt, v.rv, v.wn);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    start = v.st; sel_btn = v.se; ok_btn = v.ok; go = v.g; W = v.w;
    @(posedge clk); #1;
    check(name, v);
  endtask

  // Drive one reveal-to-check sequence: ok press then the fixed REVEAL window.
  task automatic build_reveal(input logic [3:0] p);
    add(0,0,1,0,0, 2,p, 0,0,0,1,0);
    for (int k = 0; k < 3; k++) add(0,0,0,0,0, 2,p, 0,0,0,1,0);
    add(0,0,0,0,0, 3,p, 1,0,0,0,0);
  endtask

  initial begin
    // Power-on / held-ok sequence
    add(0,0,1,0,0, 0,0, 0,0,0,0,0);
    add(1,0,1,0,0, 1,0, 0,0,0,0,0);
    add(1,0,1,0,0, 1,0, 0,0,0,0,0);
    add(0,0,1,0,0, 1,0, 0,0,0,0,0);
    add(0,0,0,0,0, 1,0, 0,0,0,0,0);
    // 13 cursor presses, wrap 11 -> 0
    for (int k = 1; k <= 13; k++) begin
      add(0,1,0,0,0, 1,4'(k % 12), 0,0,0,0,0);
      add(0,0,0,0,0, 1,4'(k % 12), 0,0,0,0,0);
    end
    // sel+ok together: ok wins, cursor stays 1; buttons ignored in REVEAL
    add(0,1,1,0,0, 2,1, 0,0,0,1,0);
    add(0,0,0,0,0, 2,1, 0,0,0,1,0);
    add(0,1,1,0,0, 2,1, 0,0,0,1,0);
    add(0,0,0,0,0, 2,1, 0,0,0,1,0);
    add(0,0,0,0,0, 3,1, 1,0,0,0,0);
    add(0,0,0,1,0, 4,1, 0,0,0,0,0);
    add(0,0,0,0,0, 7,1, 0,0,1,0,0);
    add(0,0,0,0,0, 1,0, 0,0,0,0,0);
    // Hit, no win at cursor 5
    for (int k = 1; k <= 5; k++) begin
      add(0,1,0,0,0, 1,4'(k), 0,0,0,0,0);
      add(0,0,0,0,0, 1,4'(k), 0,0,0,0,0);
    end
    build_reveal(4'd5);
    add(0,0,0,0,1, 4,5, 0,0,0,0,0);
    add(0,0,0,1,0, 5,5, 0,1,0,0,0);
    add(0,0,0,0,1, 6,5, 0,0,0,0,0);
    add(0,0,0,0,0, 1,5, 0,0,0,0,0);
    // Hit with win
    build_reveal(4'd5);
    add(0,0,0,0,0, 4,5, 0,0,0,0,0);
    add(0,0,0,1,0, 5,5, 0,1,0,0,0);
    add(0,0,0,0,0, 6,5, 0,0,0,0,0);
    add(0,0,0,0,1, 8,5, 0,0,0,0,1);
    for (int k = 0; k < 20; k++) add(0,0,0,0,0, 8,5, 0,0,0,0,1);
    add(1,0,0,0,0, 0,5, 0,0,0,0,0);
    add(0,0,0,0,0, 0,5, 0,0,0,0,0);

    // Reset asserted with ok held high
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", mk(0,0,1,0,0, 0,0, 0,0,0,0,0));
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply($sformatf("row%0d", i), vq[i]);

    // Asynchronous reset while in REVEAL with timer=2
    apply("re_start",  mk(1,0,0,0,0, 1,0, 0,0,0,0,0));
    apply("re_rel",    mk(0,0,0,0,0, 1,0, 0,0,0,0,0));
    apply("re_ok",     mk(0,0,1,0,0, 2,0, 0,0,0,1,0));
    apply("re_t1",     mk(0,0,1,0,0, 2,0, 0,0,0,1,0));
    apply("re_t2",     mk(0,0,1,0,0, 2,0, 0,0,0,1,0));
    #2 rst = 1'b1;
    #1 check("rst_in_reveal", mk(0,0,1,0,0, 0,0, 0,0,0,0,0));
    @(posedge clk); #1;
    check("rst_held", mk(0,0,1,0,0, 0,0, 0,0,0,0,0));
    rst = 1'b0;
    apply("post_idle",   mk(0,0,1,0,0, 0,0, 0,0,0,0,0));
    apply("post_start",  mk(1,0,1,0,0, 1,0, 0,0,0,0,0));
    apply("post_okheld", mk(0,0,1,0,0, 1,0, 0,0,0,0,0));
    apply("post_okrel",  mk(0,0,0,0,0, 1,0, 0,0,0,0,0));
    apply("post_ok",     mk(0,0,1,0,0, 2,0, 0,0,0,1,0));
    for (int k = 0; k < 3; k++) apply("post_rev", mk(0,0,0,0,0, 2,0, 0,0,0,1,0));
    apply("post_a",      mk(0,0,0,0,0, 3,0, 1,0,0,0,0));
    // Asynchronous reset during the A cycle
    #2 rst = 1'b1;
    #1 check("rst_in_a", mk(0,0,0,0,0, 0,0, 0,0,0,0,0));
    @(posedge clk); #1;
    rst = 1'b0;
    apply("post2_idle",  mk(0,0,0,0,0, 0,0, 0,0,0,0,0));
    apply("post2_start", mk(1,0,0,0,0, 1,0, 0,0,0,0,0));
    apply("post2_sel",   mk(0,1,0,0,0, 1,1, 0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
